// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
//
// Purpose:
//   32 x 32-bit MIPS general-purpose register file sitting at the end of the
//   writeback stage. It provides two combinational read ports for the ALU
//   operand path and one synchronous write port. A small tracking block
//   records the most recent committed write so that control logic and
//   checkers can see what the writeback stage last retired. $zero (index
//   ZERO_REG) always reads 0 and silently drops writes.
//
// Build option:
//   REG_FILE_BYPASS_EN - when defined, each read port forwards wr_data
//                        combinationally if it addresses the register being
//                        written in the same cycle (never for ZERO_REG).
//                        When undefined, reads come straight from the array.
//
// Ports:
//   clk            in   system clock, rising-edge active
//   reset          in   asynchronous, active-high; clears every register and
//                       all tracking state immediately
//   rs_addr        in   [ADDR_W-1:0] read port A index
//   rt_addr        in   [ADDR_W-1:0] read port B index
//   rs_data        out  [DATA_W-1:0] read port A data
//   rt_data        out  [DATA_W-1:0] read port B data
//   wr_en          in   regwrite strobe from control
//   wr_addr        in   [ADDR_W-1:0] destination index (rt / rd / $31)
//   wr_data        in   [DATA_W-1:0] writeback data (ALU, load, PC+4)
//   last_wr_addr   out  [ADDR_W-1:0] index of the most recent committed write
//   last_wr_valid  out  a committed write has happened since reset
//   wr_count       out  [15:0] committed writes since reset, saturating
//
// Write-port protocol:
//   There is no back-pressure. A write commits on every rising clk edge where
//   reset is low, wr_en is 1 and wr_addr differs from ZERO_REG. wr_addr and
//   wr_data only matter while wr_en is 1; wr_addr must be a known value then.
// -----------------------------------------------------------------------------
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] last_wr_addr,
    output logic              last_wr_valid,
    output logic [15:0]       wr_count
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
    localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

    // -------------------------------------------------------------------------
    // Storage and tracking state
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];

    logic [ADDR_W-1:0] last_wr_addr_q;
    logic [ADDR_W-1:0] last_wr_addr_d;
    logic              last_wr_valid_q;
    logic              last_wr_valid_d;
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    // A write "commits" only when it actually changes architectural state;
    // writes aimed at $zero are dropped and are not counted.
    logic wr_commit;
    assign wr_commit = wr_en && (wr_addr != ZERO_IDX);

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Committed-write tracking
    // -------------------------------------------------------------------------
    always_comb begin
        last_wr_addr_d  = last_wr_addr_q;
        last_wr_valid_d = last_wr_valid_q;
        wr_count_d      = wr_count_q;
        if (wr_commit) begin
            last_wr_addr_d  = wr_addr;
            last_wr_valid_d = 1'b1;
            // Hold at the maximum rather than wrapping back to zero.
            if (wr_count_q != COUNT_MAX) begin
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_wr_addr_q  <= '0;
            last_wr_valid_q <= 1'b0;
            wr_count_q      <= '0;
        end else begin
            last_wr_addr_q  <= last_wr_addr_d;
            last_wr_valid_q <= last_wr_valid_d;
            wr_count_q      <= wr_count_d;
        end
    end

    assign last_wr_addr  = last_wr_addr_q;
    assign last_wr_valid = last_wr_valid_q;
    assign wr_count      = wr_count_q;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rs_array;
    logic [DATA_W-1:0] rt_array;

    // Index ZERO_REG is forced to 0 here rather than relying on the array
    // entry, so the guarantee holds regardless of array contents.
    assign rs_array = (rs_addr == ZERO_IDX) ? '0 : regs_q[rs_addr];
    assign rt_array = (rt_addr == ZERO_IDX) ? '0 : regs_q[rt_addr];

`ifdef REG_FILE_BYPASS_EN
    // Write-through forwarding: a reader of the register being written this
    // cycle sees the incoming value before the edge. wr_commit already
    // excludes ZERO_REG, so $zero is never forwarded.
    logic rs_fwd;
    logic rt_fwd;

    assign rs_fwd  = wr_commit && (wr_addr == rs_addr);
    assign rt_fwd  = wr_commit && (wr_addr == rt_addr);
    assign rs_data = rs_fwd ? wr_data : rs_array;
    assign rt_data = rt_fwd ? wr_data : rt_array;
`else
    // Pure array read: a same-cycle write becomes visible only after the edge.
    assign rs_data = rs_array;
    assign rt_data = rt_array;
`endif

    // -------------------------------------------------------------------------
    // Protocol check: the destination index must be known whenever the
    // regwrite strobe is high, otherwise the array update is undefined.
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    wr_addr_known_a : assert property (
        @(posedge clk) disable iff (reset) wr_en |-> !$isunknown(wr_addr)
    );
`endif

endmodule
